// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, registers the fetched word, keeps the MIPS delay slot.
// Optional performance counters are enabled with `define FETCH_PERF_COUNTERS_EN.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          ADDR_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pcAddress,
  input  logic [31:0] pcDataOutput,
  input  logic        stall,
  input  logic        redirectValid,
  input  logic [31:0] redirectTarget,
  output logic        instrValid,
  output logic [31:0] instruction,
  output logic [31:0] instrPc,
  output logic        fetchFault
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0] fetchCount,
  output logic [31:0] stallCount
`endif
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("RESET_PC must be word aligned");
  end
  if ((ADDR_WIDTH < 2) || (ADDR_WIDTH > 32)) begin : g_bad_addr_width
    $error("ADDR_WIDTH must lie in 2..32");
  end

  state_t      state_r, state_s;
  logic [31:0] fetch_pc_r, fetch_pc_s;
  logic        valid_r, valid_s;
  logic [31:0] instr_r, instr_s;
  logic [31:0] instr_pc_r, instr_pc_s;
  logic        fault_r, fault_s;
  logic        pend_valid_r, pend_valid_s;
  logic [31:0] pend_target_r, pend_target_s;
  logic        misaligned_s;

  assign misaligned_s = redirectValid && (redirectTarget[1:0] != 2'b00);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= BOOT;
      fetch_pc_r    <= RESET_PC;
      valid_r       <= 1'b0;
      instr_r       <= 32'h0000_0000;
      instr_pc_r    <= 32'h0000_0000;
      fault_r       <= 1'b0;
      pend_valid_r  <= 1'b0;
      pend_target_r <= 32'h0000_0000;
    end else begin
      state_r       <= state_s;
      fetch_pc_r    <= fetch_pc_s;
      valid_r       <= valid_s;
      instr_r       <= instr_s;
      instr_pc_r    <= instr_pc_s;
      fault_r       <= fault_s;
      pend_valid_r  <= pend_valid_s;
      pend_target_r <= pend_target_s;
    end
  end

  // Next-state and next-PC selection; the redirect cycle still captures its word (delay slot).
  always_comb begin
    state_s       = state_r;
    fetch_pc_s    = fetch_pc_r;
    valid_s       = valid_r;
    instr_s       = instr_r;
    instr_pc_s    = instr_pc_r;
    fault_s       = fault_r;
    pend_valid_s  = pend_valid_r;
    pend_target_s = pend_target_r;
    case (state_r)
      BOOT: begin
        state_s = RUN;
        if (misaligned_s) begin
          state_s = FAULT;
          fault_s = 1'b1;
        end else if (redirectValid) begin
          fetch_pc_s = redirectTarget;
        end else begin
          fetch_pc_s = fetch_pc_r;
        end
      end
      RUN: begin
        if (misaligned_s) begin
          state_s      = FAULT;
          fault_s      = 1'b1;
          valid_s      = 1'b0;
          pend_valid_s = 1'b0;
        end else if (stall) begin
          // Last redirect seen during a stall wins.
          if (redirectValid) begin
            pend_valid_s  = 1'b1;
            pend_target_s = redirectTarget;
          end else begin
            pend_valid_s = pend_valid_r;
          end
        end else begin
          instr_s      = pcDataOutput;
          instr_pc_s   = fetch_pc_r;
          valid_s      = 1'b1;
          pend_valid_s = 1'b0;
          if (redirectValid) begin
            fetch_pc_s = redirectTarget;
          end else if (pend_valid_r) begin
            fetch_pc_s = pend_target_r;
          end else begin
            fetch_pc_s = fetch_pc_r + 32'd4;
          end
        end
      end
      FAULT: begin
        state_s = FAULT;
      end
      default: begin
        state_s = FAULT;
        fault_s = 1'b1;
        valid_s = 1'b0;
      end
    endcase
  end

  assign pcAddress   = fetch_pc_r;
  assign instrValid  = valid_r;
  assign instruction = instr_r;
  assign instrPc     = instr_pc_r;
  assign fetchFault  = fault_r;

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_count_r;
  logic [31:0] stall_count_r;
  logic        fetch_inc_s;
  logic        stall_inc_s;

  assign fetch_inc_s = (state_r == RUN) && !stall && !misaligned_s;
  assign stall_inc_s = (state_r == RUN) && stall;

  // Free-running event counters; they only advance in RUN so they freeze in FAULT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_r <= 32'h0000_0000;
      stall_count_r <= 32'h0000_0000;
    end else begin
      fetch_count_r <= fetch_count_r + {31'd0, fetch_inc_s};
      stall_count_r <= stall_count_r + {31'd0, stall_inc_s};
    end
  end

  assign fetchCount = fetch_count_r;
  assign stallCount = stall_count_r;
`endif

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Instruction fetch stage directly upstream of the byte-addressed memory block's instruction port.
- Owns the program counter and drives the memory's pcAddress. Captures the returned pcDataOutput word into an output register for decode.
- Handles decode stall, branch/jump redirects with the MIPS branch-delay slot preserved, and misaligned-target faults.
- Memory instruction read is combinational: data for pcAddress is valid in the same cycle.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into the fetch PC on reset; must be word aligned.
- ADDR_WIDTH, 16, number of low PC bits the memory decodes; bits above it are driven but ignored by memory.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- pcAddress  output  32  fetch address to memory (equals fetchPc register)
- pcDataOutput  input  32  instruction word returned by memory for pcAddress, same cycle
- stall  input  1  decode cannot accept; hold outputs and PC
- redirectValid  input  1  one-cycle pulse: branch/jump taken
- redirectTarget  input  32  target PC, sampled when redirectValid=1
- instrValid  output  1  instruction/instrPc valid for decode
- instruction  output  32  registered instruction word
- instrPc  output  32  address instruction was fetched from
- fetchFault  output  1  sticky: misaligned redirect target seen

Behaviour:
- Reset (async, rst=1):
  - fetchPc=RESET_PC, instrValid=0, instruction=0, instrPc=0, fetchFault=0.
  - pendingValid=0, pendingTarget=0, state=BOOT.
- States:
  - BOOT: single cycle after reset release; instrValid stays 0; next edge goes to RUN. It does not capture, but it does load fetchPc if a redirect is taken.
  - RUN: normal fetch.
  - FAULT: terminal until reset.
- RUN, stall=0, rising edge:
  - instruction<=pcDataOutput, instrPc<=fetchPc, instrValid<=1.
  - fetchPc<=nextPc.
- nextPc priority:
  - redirectValid=1: redirectTarget.
  - else pendingValid=1: pendingTarget, and pendingValid<=0.
  - else fetchPc+4.
- Delay slot:
  - The word fetched in the redirect cycle is captured as valid; it is the delay slot.
  - The target is fetched in the following cycle. No bubble and no squash.
- RUN, stall=1:
  - instruction, instrPc, instrValid and fetchPc all hold.
  - redirectValid=1 during stall: pendingTarget<=redirectTarget, pendingValid<=1. A later redirect while pending overwrites it (last wins).
  - The first unstalled edge captures the delay slot at the held fetchPc, then loads fetchPc from pendingTarget.
- Simultaneous redirect and pending on an unstalled edge: redirectTarget wins; pendingValid clears.
- Misaligned target (redirectTarget[1:0]!=0 when sampled, stalled or not):
  - Next edge: state=FAULT, fetchFault=1, instrValid=0.
  - fetchPc holds its last aligned value; pending is discarded.
- FAULT: all registers hold; stall and redirects are ignored; only rst exits.
- Arithmetic: fetchPc+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 0. Memory sees only pcAddress[ADDR_WIDTH-1:0], so wraps every 2^ADDR_WIDTH bytes.
- Reset mid-stall or with a pending redirect: everything returns to reset values immediately (async); the pending target is lost.
- instrValid deasserts only on reset or fault. Decode qualifies consumption with instrValid & ~stall.

Optional Feature:
- Macro: FETCH_PERF_COUNTERS_EN.
- Defined:
  - Adds outputs fetchCount[31:0] and stallCount[31:0], both reset to 0.
  - fetchCount increments on every edge that loads a new instruction (RUN, stall=0).
  - stallCount increments on every RUN edge with stall=1.
  - Both wrap at 2^32 and freeze in FAULT.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset release, RESET_PC=0, memory words 0x11,0x22,0x33 at 0,4,8 -> BOOT cycle instrValid=0; then instruction/instrPc = 0x11/0, 0x22/4, 0x33/8 on successive cycles.
- redirectValid with target 0x100 while fetchPc=8 -> next outputs 0x33/8 (delay slot) then word@0x100/0x100, with no gap.
- stall=1 for 3 cycles with redirect to 0x200 pulsed in stall cycle 2 -> outputs frozen for 3 cycles; after release, delay slot @fetchPc, then word@0x200. Under FETCH_PERF_COUNTERS_EN, stallCount=3.
- Redirect target 0x102 -> fetchFault=1, instrValid=0 from next edge; later redirect to 0x300 ignored; rst returns fetchPc=RESET_PC and fetchFault=0.
- fetchPc forced to 0xFFFF_FFFC by redirect -> next instrPc 0xFFFF_FFFC, following fetchPc 0x0000_0000.
- rst asserted asynchronously mid-stall with pendingValid=1 -> outputs zero immediately without a clock edge; after release, fetch resumes at RESET_PC and does not jump to the old target.
